// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter: op and port encodings plus
// the result-register state type.
package shift_pkg;

  localparam int  DATA_W  = 32;
  localparam int  SHAMT_W = 5;

  localparam logic OP_SLL   = 1'b0;
  localparam logic OP_SRA   = 1'b1;

  localparam logic PORT_ALU = 1'b0;
  localparam logic PORT_MD  = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } res_state_e;

endpackage : shift_pkg

// File: rtl/shift_core_32.sv
// Combinational 32-bit logarithmic shifter: five mux stages (1/2/4/8/16),
// SLL zero-fills from bit 0, SRA fills with the original sign bit.
module shift_core_32
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0]  data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               op_i,
  output logic [DATA_W-1:0]  data_o
);

  logic              is_sra;
  logic              fill;
  logic [DATA_W-1:0] s0;
  logic [DATA_W-1:0] s1;
  logic [DATA_W-1:0] s2;
  logic [DATA_W-1:0] s3;
  logic [DATA_W-1:0] s4;

  assign is_sra = (op_i == OP_SRA);
  assign fill   = is_sra ? data_i[31] : 1'b0;

  // Each stage either passes through or shifts by its power of two; the
  // SRA direction pulls the fill bit in from the top.
  assign s0 = !shamt_i[0] ? data_i :
              is_sra      ? {fill, data_i[31:1]} :
                            {data_i[30:0], 1'b0};

  assign s1 = !shamt_i[1] ? s0 :
              is_sra      ? {{2{fill}}, s0[31:2]} :
                            {s0[29:0], 2'b00};

  assign s2 = !shamt_i[2] ? s1 :
              is_sra      ? {{4{fill}}, s1[31:4]} :
                            {s1[27:0], 4'h0};

  assign s3 = !shamt_i[3] ? s2 :
              is_sra      ? {{8{fill}}, s2[31:8]} :
                            {s2[23:0], 8'h00};

  assign s4 = !shamt_i[4] ? s3 :
              is_sra      ? {{16{fill}}, s3[31:16]} :
                            {s3[15:0], 16'h0000};

  assign data_o = s4;

endmodule : shift_core_32

// File: rtl/shift_arbiter.sv
// Two-port round-robin front end to a shared shift core, with a single
// registered result stage that supports backpressure.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic               clock,
  input  logic               reset,

  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_data,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic               req0_op,
  input  logic [TAG_W-1:0]   req0_tag,

  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_data,
  input  logic [SHAMT_W-1:0] req1_shamt,
  input  logic               req1_op,
  input  logic [TAG_W-1:0]   req1_tag,

  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_id,
  output logic [TAG_W-1:0]   out_tag
);

  res_state_e         state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               id_q, id_d;
  logic [TAG_W-1:0]   tag_q, tag_d;

  logic               can_accept;
  logic               grant0;
  logic               grant1;
  logic               accept;
  logic               sel_port;
  logic [DATA_W-1:0]  sel_data;
  logic [SHAMT_W-1:0] sel_shamt;
  logic               sel_op;
  logic [TAG_W-1:0]   sel_tag;
  logic [DATA_W-1:0]  shift_out;

  // A draining result frees the register in the same cycle it is taken.
  assign can_accept = (state_q == EMPTY) || out_ready;

  // Contested cycles go to the port that did not win last time.
  assign grant0 = req0_valid && (!req1_valid || (last_grant_q == PORT_MD));
  assign grant1 = req1_valid && (!req0_valid || (last_grant_q == PORT_ALU));

  assign req0_ready = grant0 && can_accept;
  assign req1_ready = grant1 && can_accept;
  assign accept     = req0_ready || req1_ready;

  assign sel_port  = grant1 ? PORT_MD : PORT_ALU;
  assign sel_data  = grant1 ? req1_data  : req0_data;
  assign sel_shamt = grant1 ? req1_shamt : req0_shamt;
  assign sel_op    = grant1 ? req1_op    : req0_op;
  assign sel_tag   = grant1 ? req1_tag   : req0_tag;

  shift_core_32 u_core (
    .data_i  (sel_data),
    .shamt_i (sel_shamt),
    .op_i    (sel_op),
    .data_o  (shift_out)
  );

  // Result register next state; data is held (not cleared) when it drains.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    data_d       = data_q;
    id_d         = id_q;
    tag_d        = tag_q;
    if (accept) begin
      state_d      = FULL;
      last_grant_d = sel_port;
      data_d       = shift_out;
      id_d         = sel_port;
      tag_d        = sel_tag;
    end else if (out_ready) begin
      state_d      = EMPTY;
    end
  end

  // last_grant resets to port 1 so port 0 wins the first contest.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= EMPTY;
      last_grant_q <= PORT_MD;
      data_q       <= '0;
      id_q         <= PORT_ALU;
      tag_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      id_q         <= id_d;
      tag_q        <= tag_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_id    = id_q;
  assign out_tag   = tag_q;

endmodule : shift_arbiter

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter: handshake, round-robin,
// shift corner cases, backpressure, back-to-back and async reset.
module tb_shift_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0Valid, req0Ready, req0Op;
  logic [31:0] req0Data;
  logic [4:0]  req0Shamt;
  logic [3:0]  req0Tag;
  logic        req1Valid, req1Ready, req1Op;
  logic [31:0] req1Data;
  logic [4:0]  req1Shamt;
  logic [3:0]  req1Tag;
  logic        outValid, outReady, outId;
  logic [31:0] outData;
  logic [3:0]  outTag;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clock = ~clock;

  shift_arbiter #(.TAG_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0Valid),
    .req0_ready (req0Ready),
    .req0_data  (req0Data),
    .req0_shamt (req0Shamt),
    .req0_op    (req0Op),
    .req0_tag   (req0Tag),
    .req1_valid (req1Valid),
    .req1_ready (req1Ready),
    .req1_data  (req1Data),
    .req1_shamt (req1Shamt),
    .req1_op    (req1Op),
    .req1_tag   (req1Tag),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .out_data   (outData),
    .out_id     (outId),
    .out_tag    (outTag)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clearReqs;
    req0Valid = 1'b0; req0Data = '0; req0Shamt = '0; req0Op = 1'b0; req0Tag = '0;
    req1Valid = 1'b0; req1Data = '0; req1Shamt = '0; req1Op = 1'b0; req1Tag = '0;
  endtask

  task automatic pulseReset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    clearReqs;
    outReady = 1'b1;
    reset = 1'b1;
    #1;
    assertCount++;
    if (outValid !== 1'b0 || outData !== 32'h0 || outId !== 1'b0 || outTag !== 4'h0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: got valid=%b data=%h id=%b tag=%h, expected 0/0/0/0",
               outValid, outData, outId, outTag);
    end
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_single;
    req0Valid = 1'b1; req0Data = 32'h0000_0001; req0Shamt = 5'd4; req0Op = 1'b0; req0Tag = 4'd3;
    outReady = 1'b1;
    #1;
    assertCount++;
    if (req0Ready !== 1'b1 || req1Ready !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL single_ready: got r0=%b r1=%b, expected 1/0", req0Ready, req1Ready);
    end
    tick;
    clearReqs;
    assertCount++;
    if (outValid !== 1'b1 || outData !== 32'h0000_0010 || outId !== 1'b0 || outTag !== 4'd3) begin
      failCount++;
      $display("[TB] FAIL single_result: got v=%b d=%h id=%b tag=%h, expected 1/00000010/0/3",
               outValid, outData, outId, outTag);
    end
    tick;
    assertCount++;
    if (outValid !== 1'b0 || outData !== 32'h0000_0010) begin
      failCount++;
      $display("[TB] FAIL single_drain: got v=%b d=%h, expected 0/00000010", outValid, outData);
    end
  endtask

  task automatic test_round_robin;
    int  cnt0 = 0;
    int  cnt1 = 0;
    logic expPort;
    logic [31:0] expData;
    pulseReset;
    outReady = 1'b1;
    for (int k = 0; k < 16; k++) begin
      req0Valid = 1'b1; req0Data = k; req0Shamt = 5'd1; req0Op = 1'b0; req0Tag = 4'(k);
      req1Valid = 1'b1; req1Data = 32'h100 + k; req1Shamt = 5'd0; req1Op = 1'b0; req1Tag = 4'(15 - k);
      expPort = k[0];
      expData = expPort ? 32'h100 + k : k * 2;
      #1;
      assertCount++;
      if (req0Ready !== !expPort || req1Ready !== expPort) begin
        failCount++;
        $display("[TB] FAIL rr_ready[%0d]: got r0=%b r1=%b, expected grant to port %0d",
                 k, req0Ready, req1Ready, expPort);
      end
      tick;
      assertCount++;
      if (outValid !== 1'b1 || outId !== expPort || outData !== expData) begin
        failCount++;
        $display("[TB] FAIL rr_result[%0d]: got v=%b id=%b d=%h, expected 1/%b/%h",
                 k, outValid, outId, outData, expPort, expData);
      end
      if (outId === 1'b1) cnt1++;
      else cnt0++;
    end
    clearReqs;
    assertCount++;
    if (cnt0 != 8 || cnt1 != 8) begin
      failCount++;
      $display("[TB] FAIL rr_fairness: got port0=%0d port1=%0d, expected 8/8", cnt0, cnt1);
    end
  endtask

  task automatic test_shifts;
    logic [31:0] dataVec [3]  = '{32'h8000_0000, 32'h7FFF_FFF0, 32'hDEAD_BEEF};
    logic [4:0]  shamtVec [3] = '{5'd31, 5'd4, 5'd0};
    logic        opVec [3]    = '{1'b1, 1'b1, 1'b0};
    logic [31:0] expVec [3]   = '{32'hFFFF_FFFF, 32'h07FF_FFFF, 32'hDEAD_BEEF};
    outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req1Valid = 1'b1; req1Data = dataVec[i]; req1Shamt = shamtVec[i];
      req1Op = opVec[i]; req1Tag = 4'(i + 8);
      tick;
      assertCount++;
      if (outValid !== 1'b1 || outData !== expVec[i] || outId !== 1'b1 || outTag !== 4'(i + 8)) begin
        failCount++;
        $display("[TB] FAIL shift_vec[%0d]: got v=%b d=%h id=%b tag=%h, expected 1/%h/1/%h",
                 i, outValid, outData, outId, outTag, expVec[i], 4'(i + 8));
      end
    end
    clearReqs;
    tick;
  endtask

  task automatic test_backpressure;
    outReady = 1'b0;
    req0Valid = 1'b1; req0Data = 32'h0000_00A5; req0Shamt = 5'd0; req0Op = 1'b0; req0Tag = 4'd5;
    tick;
    req0Data = 32'h1; req0Tag = 4'd1;
    req1Valid = 1'b1; req1Data = 32'h2; req1Shamt = 5'd0; req1Op = 1'b0; req1Tag = 4'd2;
    for (int c = 0; c < 5; c++) begin
      #1;
      assertCount++;
      if (req0Ready !== 1'b0 || req1Ready !== 1'b0 || outValid !== 1'b1 ||
          outData !== 32'hA5 || outId !== 1'b0 || outTag !== 4'd5) begin
        failCount++;
        $display("[TB] FAIL stall[%0d]: got r0=%b r1=%b v=%b d=%h id=%b tag=%h, expected 0/0/1/000000a5/0/5",
                 c, req0Ready, req1Ready, outValid, outData, outId, outTag);
      end
      tick;
    end
    outReady = 1'b1;
    #1;
    assertCount++;
    if (req0Ready !== 1'b0 || req1Ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL stall_release_ready: got r0=%b r1=%b, expected 0/1", req0Ready, req1Ready);
    end
    tick;
    clearReqs;
    assertCount++;
    if (outValid !== 1'b1 || outId !== 1'b1 || outData !== 32'h2 || outTag !== 4'd2) begin
      failCount++;
      $display("[TB] FAIL stall_release_result: got v=%b id=%b d=%h tag=%h, expected 1/1/00000002/2",
               outValid, outId, outData, outTag);
    end
    tick;
    assertCount++;
    if (outValid !== 1'b0 || outData !== 32'h2) begin
      failCount++;
      $display("[TB] FAIL idle_drain: got v=%b d=%h, expected 0/00000002", outValid, outData);
    end
  endtask

  task automatic test_back_to_back;
    outReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req0Valid = 1'b1; req0Data = 32'h3; req0Shamt = 5'(i * 3); req0Op = 1'b0; req0Tag = 4'(i);
      #1;
      assertCount++;
      if (req0Ready !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL b2b_ready[%0d]: got %b, expected 1", i, req0Ready);
      end
      tick;
      assertCount++;
      if (outValid !== 1'b1 || outData !== (32'h3 << (i * 3)) || outTag !== 4'(i)) begin
        failCount++;
        $display("[TB] FAIL b2b_result[%0d]: got v=%b d=%h tag=%h, expected 1/%h/%h",
                 i, outValid, outData, outTag, 32'h3 << (i * 3), 4'(i));
      end
    end
    clearReqs;
    tick;
  endtask

  task automatic test_reset_midflight;
    outReady = 1'b0;
    req0Valid = 1'b1; req0Data = 32'h0000_FFFF; req0Shamt = 5'd0; req0Op = 1'b0; req0Tag = 4'd7;
    req1Valid = 1'b0;
    tick;
    clearReqs;
    assertCount++;
    if (outValid !== 1'b1 || outData !== 32'h0000_FFFF) begin
      failCount++;
      $display("[TB] FAIL pre_reset_full: got v=%b d=%h, expected 1/0000ffff", outValid, outData);
    end
    #2;
    reset = 1'b1;
    #1;
    assertCount++;
    if (outValid !== 1'b0 || outData !== 32'h0 || outTag !== 4'h0 || outId !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL async_reset: got v=%b d=%h id=%b tag=%h, expected 0/0/0/0",
               outValid, outData, outId, outTag);
    end
    tick;
    tick;
    reset = 1'b0;
    tick;
    assertCount++;
    if (outValid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL post_reset_idle: got v=%b, expected 0", outValid);
    end
    outReady = 1'b1;
    req0Valid = 1'b1; req0Data = 32'h1; req0Tag = 4'd1;
    req1Valid = 1'b1; req1Data = 32'h2; req1Tag = 4'd2;
    #1;
    assertCount++;
    if (req0Ready !== 1'b1 || req1Ready !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL post_reset_grant: got r0=%b r1=%b, expected 1/0", req0Ready, req1Ready);
    end
    tick;
    clearReqs;
    assertCount++;
    if (outValid !== 1'b1 || outId !== 1'b0 || outData !== 32'h1) begin
      failCount++;
      $display("[TB] FAIL post_reset_result: got v=%b id=%b d=%h, expected 1/0/00000001",
               outValid, outId, outData);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_shifts;
    test_backpressure;
    test_back_to_back;
    test_reset_midflight;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule : tb_shift_arbiter
